// File: rtl/instr_queue_dispatch.sv
// Instruction-queue consumer: buffers pushed entries, expands each entry's
// copy_count into strided per-copy issues, and retires program-end markers.
module instr_queue_dispatch #(
    parameter int unsigned LOG_SUPERSCALAR_WIDTH = 3,
    parameter int unsigned ISSUE_WIDTH           = 3,
    parameter int unsigned LOG_DEPTH             = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   queue_we,
    input  logic [1:0]                             queue_instr_type,
    input  logic [LOG_SUPERSCALAR_WIDTH:0]         queue_copy_count,
    input  logic [8:0]                             queue_arith_instr,
    input  logic [2:0]                             queue_ram_instr,
    input  logic [6:0]                             queue_ld_st_instr,
    input  logic [17:0]                            cache_addr,
    input  logic [17:0]                            main_mem_addr,
    input  logic [17:0]                            d_cache_addr,
    input  logic [17:0]                            d_main_mem_addr,
    output logic                                   instr_queue_stall_push,
    output logic [ISSUE_WIDTH-1:0]                 issue_lane_valid,
    input  logic                                   issue_ready,
    output logic [1:0]                             issue_instr_type,
    output logic [8:0]                             issue_arith_instr,
    output logic [2:0]                             issue_ram_instr,
    output logic [6:0]                             issue_ld_st_instr,
    output logic [LOG_SUPERSCALAR_WIDTH:0]         issue_copy_base,
    output logic [ISSUE_WIDTH*18-1:0]              issue_cache_addr,
    output logic [ISSUE_WIDTH*18-1:0]              issue_main_mem_addr,
    output logic                                   program_complete,
    output logic                                   queue_error
);

    localparam int unsigned CW    = LOG_SUPERSCALAR_WIDTH + 1;
    localparam int unsigned AW    = 18;
    localparam int unsigned DEPTH = 1 << LOG_DEPTH;
    localparam int unsigned OW    = LOG_DEPTH + 1;

    typedef struct packed {
        logic [1:0]    instr_type;
        logic [CW-1:0] copy_count;
        logic [8:0]    arith;
        logic [2:0]    ram;
        logic [6:0]    ld_st;
        logic [AW-1:0] cache_base;
        logic [AW-1:0] mem_base;
        logic [AW-1:0] cache_stride;
        logic [AW-1:0] mem_stride;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wr_ptr;
    logic [LOG_DEPTH-1:0]  rd_ptr;
    logic [OW-1:0]         count;
    logic [CW-1:0]         issued;
    logic                  error_q;

    entry_t                head;
    logic                  head_valid;
    logic                  is_end;
    logic                  is_zero;
    logic [CW-1:0]         remaining;
    logic [CW-1:0]         lanes;
    logic                  fire;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Head decode: how many copies go out this cycle and whether the head retires.
    always_comb begin
        head       = mem[rd_ptr];
        head_valid = (count != '0);
        is_end     = head_valid && (head.instr_type == 2'd3);
        is_zero    = head_valid && !is_end && (head.copy_count == '0);
        remaining  = head.copy_count - issued;
        lanes      = '0;
        if (head_valid && !is_end && !is_zero)
            lanes = (remaining > CW'(ISSUE_WIDTH)) ? CW'(ISSUE_WIDTH) : remaining;
        fire = issue_ready && (lanes != '0);
        // Program-end and zero-count entries leave without waiting for the consumer.
        pop  = is_end || is_zero || (fire && ((issued + lanes) == head.copy_count));
        push = queue_we && (count != OW'(DEPTH));
        drop = queue_we && (count == OW'(DEPTH));
    end

    // Per-lane issue outputs; everything reads zero when no lane is valid.
    always_comb begin
        issue_lane_valid    = '0;
        issue_instr_type    = '0;
        issue_arith_instr   = '0;
        issue_ram_instr     = '0;
        issue_ld_st_instr   = '0;
        issue_cache_addr    = '0;
        issue_main_mem_addr = '0;
        issue_copy_base     = issued;
        if (lanes != '0) begin
            issue_instr_type  = head.instr_type;
            issue_arith_instr = head.arith;
            issue_ram_instr   = head.ram;
            issue_ld_st_instr = head.ld_st;
        end
        for (int unsigned w = 0; w < ISSUE_WIDTH; w++) begin
            if (CW'(w) < lanes) begin
                issue_lane_valid[w] = 1'b1;
                issue_cache_addr[w*AW +: AW] =
                    head.cache_base + (AW'(issued) + AW'(w)) * head.cache_stride;
                issue_main_mem_addr[w*AW +: AW] =
                    head.mem_base + (AW'(issued) + AW'(w)) * head.mem_stride;
            end
        end
        // One slot stays free for the push already in flight when stall is seen.
        instr_queue_stall_push = (count >= OW'(DEPTH - 1));
        program_complete       = is_end;
        queue_error            = error_q;
    end

    // Entry storage; contents need no reset since pointers qualify them.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{instr_type: queue_instr_type, copy_count: queue_copy_count,
                             arith: queue_arith_instr, ram: queue_ram_instr,
                             ld_st: queue_ld_st_instr, cache_base: cache_addr,
                             mem_base: main_mem_addr, cache_stride: d_cache_addr,
                             mem_stride: d_main_mem_addr};
    end

    // Pointers, occupancy, head copy counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            issued  <= '0;
            error_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + LOG_DEPTH'(1);
                issued <= '0;
            end else if (fire) begin
                issued <= issued + lanes;
            end
            case ({push, pop})
                2'b10:   count <= count + OW'(1);
                2'b01:   count <= count - OW'(1);
                default: count <= count;
            endcase
            if (drop || is_zero)
                error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_queue_dispatch.sv
// Self-checking bench for instr_queue_dispatch: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_instr_queue_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        queue_we;
    logic [1:0]  queue_instr_type;
    logic [3:0]  queue_copy_count;
    logic [8:0]  queue_arith_instr;
    logic [2:0]  queue_ram_instr;
    logic [6:0]  queue_ld_st_instr;
    logic [17:0] cache_addr, main_mem_addr, d_cache_addr, d_main_mem_addr;
    logic        instr_queue_stall_push;
    logic [2:0]  issue_lane_valid;
    logic        issue_ready;
    logic [1:0]  issue_instr_type;
    logic [8:0]  issue_arith_instr;
    logic [2:0]  issue_ram_instr;
    logic [6:0]  issue_ld_st_instr;
    logic [3:0]  issue_copy_base;
    logic [53:0] issue_cache_addr;
    logic [53:0] issue_main_mem_addr;
    logic        program_complete;
    logic        queue_error;

    int vectors = 0;
    int miscompares = 0;

    instr_queue_dispatch dut (
        .clk                    (clk),
        .reset                  (reset),
        .queue_we               (queue_we),
        .queue_instr_type       (queue_instr_type),
        .queue_copy_count       (queue_copy_count),
        .queue_arith_instr      (queue_arith_instr),
        .queue_ram_instr        (queue_ram_instr),
        .queue_ld_st_instr      (queue_ld_st_instr),
        .cache_addr             (cache_addr),
        .main_mem_addr          (main_mem_addr),
        .d_cache_addr           (d_cache_addr),
        .d_main_mem_addr        (d_main_mem_addr),
        .instr_queue_stall_push (instr_queue_stall_push),
        .issue_lane_valid       (issue_lane_valid),
        .issue_ready            (issue_ready),
        .issue_instr_type       (issue_instr_type),
        .issue_arith_instr      (issue_arith_instr),
        .issue_ram_instr        (issue_ram_instr),
        .issue_ld_st_instr      (issue_ld_st_instr),
        .issue_copy_base        (issue_copy_base),
        .issue_cache_addr       (issue_cache_addr),
        .issue_main_mem_addr    (issue_main_mem_addr),
        .program_complete       (program_complete),
        .queue_error            (queue_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        int          n;
        logic [8:0]  ar;
        logic [2:0]  ram;
        logic [6:0]  ls;
        logic [17:0] ca, ma, dca, dma;
    } ent_t;

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [1:0] t, input int n, input logic [8:0] ar,
                            input logic [17:0] ca, input logic [17:0] dca,
                            input logic [17:0] ma, input logic [17:0] dma);
        queue_we          = 1'b1;
        queue_instr_type  = t;
        queue_copy_count  = 4'(n);
        queue_arith_instr = ar;
        queue_ram_instr   = 3'(ar);
        queue_ld_st_instr = 7'(ar);
        cache_addr        = ca;
        d_cache_addr      = dca;
        main_mem_addr     = ma;
        d_main_mem_addr   = dma;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        queue_we = 1'b0;
        issue_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [159:0] all_out;
        do_reset();
        all_out = {instr_queue_stall_push, issue_lane_valid, issue_instr_type, issue_arith_instr,
                   issue_ram_instr, issue_ld_st_instr, issue_copy_base, issue_cache_addr,
                   issue_main_mem_addr, program_complete, queue_error};
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
    endtask

    task automatic test_single_arith();
        do_reset();
        issue_ready = 1'b1;
        set_push(2'd2, 1, 9'h1A5, 18'd0, 18'd0, 18'd0, 18'd0);
        cyc();
        queue_we = 1'b0;
        vectors++;
        if (issue_lane_valid !== 3'b001 || issue_copy_base !== 4'd0 ||
            issue_instr_type !== 2'd2 || issue_arith_instr !== 9'h1A5) begin
            miscompares++;
            $display("FAIL single_arith got=%b/%0d/%0d/%h exp=001/0/2/1a5",
                     issue_lane_valid, issue_copy_base, issue_instr_type, issue_arith_instr);
        end
        cyc();
        vectors++;
        if (issue_lane_valid !== 3'b000 || instr_queue_stall_push !== 1'b0) begin
            miscompares++;
            $display("FAIL single_arith_empty got=%b exp=000", issue_lane_valid);
        end
    endtask

    task automatic test_ld_st_expand();
        logic [2:0]  exp_v  [3] = '{3'b111, 3'b111, 3'b011};
        int          exp_b  [3] = '{0, 3, 6};
        logic [53:0] exp_ca [3];
        exp_ca[0] = {18'd108, 18'd104, 18'd100};
        exp_ca[1] = {18'd120, 18'd116, 18'd112};
        exp_ca[2] = {18'd0,   18'd128, 18'd124};
        do_reset();
        set_push(2'd0, 8, 9'h055, 18'd100, 18'd4, 18'd0, 18'd0);
        cyc();
        queue_we = 1'b0;
        cyc();
        // Held with ready low: still the first group.
        vectors++;
        if (issue_lane_valid !== 3'b111 || issue_copy_base !== 4'd0) begin
            miscompares++;
            $display("FAIL ldst_hold got=%b/%0d exp=111/0", issue_lane_valid, issue_copy_base);
        end
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (issue_lane_valid !== exp_v[i] || issue_copy_base !== 4'(exp_b[i]) ||
                (issue_cache_addr & {{18{exp_v[i][2]}}, {18{exp_v[i][1]}}, {18{exp_v[i][0]}}}) !== exp_ca[i]) begin
                miscompares++;
                $display("FAIL ldst_group%0d got=%b/%0d/%h exp=%b/%0d/%h", i, issue_lane_valid,
                         issue_copy_base, issue_cache_addr, exp_v[i], exp_b[i], exp_ca[i]);
            end
            cyc();
        end
        vectors++;
        if (issue_lane_valid !== 3'b000) begin
            miscompares++;
            $display("FAIL ldst_popped got=%b exp=000", issue_lane_valid);
        end
    endtask

    task automatic test_ram_wrap();
        do_reset();
        issue_ready = 1'b1;
        set_push(2'd1, 3, 9'h003, 18'd0, 18'd0, 18'h3FFFE, 18'd1);
        cyc();
        queue_we = 1'b0;
        vectors++;
        if (issue_lane_valid !== 3'b111 || issue_main_mem_addr !== {18'h00000, 18'h3FFFF, 18'h3FFFE}) begin
            miscompares++;
            $display("FAIL ram_wrap got=%b/%h exp=111/%h", issue_lane_valid, issue_main_mem_addr,
                     {18'h00000, 18'h3FFFF, 18'h3FFFE});
        end
        cyc();
    endtask

    task automatic test_stall_full();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_push(2'd2, 1, 9'(i), 18'd0, 18'd0, 18'd0, 18'd0);
            cyc();
            vectors++;
            if (instr_queue_stall_push !== (i + 1 >= 15)) begin
                miscompares++;
                $display("FAIL stall_occ%0d got=%b exp=%b", i + 1, instr_queue_stall_push, i + 1 >= 15);
            end
        end
        set_push(2'd2, 1, 9'd15, 18'd0, 18'd0, 18'd0, 18'd0);
        cyc();
        vectors++;
        if (queue_error !== 1'b0 || instr_queue_stall_push !== 1'b1) begin
            miscompares++;
            $display("FAIL push16 got=err%b stall%b exp=err0 stall1", queue_error, instr_queue_stall_push);
        end
        set_push(2'd2, 1, 9'd16, 18'd0, 18'd0, 18'd0, 18'd0);
        cyc();
        queue_we = 1'b0;
        vectors++;
        if (queue_error !== 1'b1) begin
            miscompares++;
            $display("FAIL push17_dropped got=%b exp=1", queue_error);
        end
        issue_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (issue_lane_valid !== 3'b001 || issue_arith_instr !== 9'(i)) begin
                miscompares++;
                $display("FAIL drain%0d got=%b/%0d exp=001/%0d", i, issue_lane_valid, issue_arith_instr, i);
            end
            cyc();
        end
        vectors++;
        if (issue_lane_valid !== 3'b000 || instr_queue_stall_push !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty got=%b/%b exp=000/0", issue_lane_valid, instr_queue_stall_push);
        end
    endtask

    task automatic test_prog_end();
        do_reset();
        issue_ready = 1'b1;
        set_push(2'd2, 2, 9'd7, 18'd0, 18'd0, 18'd0, 18'd0);
        cyc();
        set_push(2'd3, 1, 9'd0, 18'd0, 18'd0, 18'd0, 18'd0);
        vectors++;
        if (issue_lane_valid !== 3'b011 || program_complete !== 1'b0) begin
            miscompares++;
            $display("FAIL progend_arith got=%b/%b exp=011/0", issue_lane_valid, program_complete);
        end
        cyc();
        queue_we = 1'b0;
        vectors++;
        if (program_complete !== 1'b1 || issue_lane_valid !== 3'b000) begin
            miscompares++;
            $display("FAIL progend_pulse got=%b/%b exp=1/000", program_complete, issue_lane_valid);
        end
        cyc();
        vectors++;
        if (program_complete !== 1'b0 || issue_lane_valid !== 3'b000) begin
            miscompares++;
            $display("FAIL progend_after got=%b/%b exp=0/000", program_complete, issue_lane_valid);
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        issue_ready = 1'b1;
        set_push(2'd0, 0, 9'd1, 18'd0, 18'd0, 18'd0, 18'd0);
        cyc();
        queue_we = 1'b0;
        vectors++;
        if (issue_lane_valid !== 3'b000 || queue_error !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_head got=%b/%b exp=000/0", issue_lane_valid, queue_error);
        end
        cyc();
        vectors++;
        if (queue_error !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_error got=%b exp=1", queue_error);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_ready = 1'b1;
        set_push(2'd0, 8, 9'd2, 18'd10, 18'd1, 18'd0, 18'd0);
        cyc();
        queue_we = 1'b0;
        cyc();
        vectors++;
        if (issue_copy_base !== 4'd3) begin
            miscompares++;
            $display("FAIL mid_base got=%0d exp=3", issue_copy_base);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        vectors++;
        if (issue_lane_valid !== 3'b000 || instr_queue_stall_push !== 1'b0 || program_complete !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got=%b/%b/%b exp=000/0/0", issue_lane_valid,
                     instr_queue_stall_push, program_complete);
        end
        set_push(2'd2, 2, 9'd9, 18'd0, 18'd0, 18'd0, 18'd0);
        cyc();
        queue_we = 1'b0;
        vectors++;
        if (issue_copy_base !== 4'd0 || issue_lane_valid !== 3'b011) begin
            miscompares++;
            $display("FAIL mid_next got=%0d/%b exp=0/011", issue_copy_base, issue_lane_valid);
        end
        cyc();
    endtask

    // Randomized traffic; the producer honours stall, like the control unit does.
    task automatic test_random();
        ent_t        mq[$];
        ent_t        h, e;
        int          mk = 0;
        int          lanes;
        bit          merr = 0;
        bit          exp_pc;
        logic [2:0]  exp_v;
        logic [17:0] ea, em;
        int          r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            lanes = 0;
            exp_pc = 0;
            if (mq.size() > 0) begin
                h = mq[0];
                if (h.t == 2'd3) exp_pc = 1;
                else if (h.n > 0) lanes = (h.n - mk < 3) ? h.n - mk : 3;
            end
            exp_v = 3'((1 << lanes) - 1);
            vectors++;
            if (issue_lane_valid !== exp_v || issue_copy_base !== 4'(mk) ||
                program_complete !== exp_pc || queue_error !== merr ||
                instr_queue_stall_push !== (mq.size() >= 15)) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc=%0d got=%b/%0d/%b/%b/%b exp=%b/%0d/%b/%b/%b", c,
                         issue_lane_valid, issue_copy_base, program_complete, queue_error,
                         instr_queue_stall_push, exp_v, mk, exp_pc, merr, mq.size() >= 15);
            end
            if (lanes > 0) begin
                vectors++;
                if (issue_instr_type !== h.t || issue_arith_instr !== h.ar ||
                    issue_ram_instr !== h.ram || issue_ld_st_instr !== h.ls) begin
                    miscompares++;
                    $display("FAIL rand_payload cyc=%0d got=%0d/%h exp=%0d/%h", c,
                             issue_instr_type, issue_arith_instr, h.t, h.ar);
                end
                for (int w = 0; w < lanes; w++) begin
                    ea = h.ca + 18'(mk + w) * h.dca;
                    em = h.ma + 18'(mk + w) * h.dma;
                    vectors++;
                    if (issue_cache_addr[w*18 +: 18] !== ea || issue_main_mem_addr[w*18 +: 18] !== em) begin
                        miscompares++;
                        $display("FAIL rand_addr cyc=%0d lane=%0d got=%h/%h exp=%h/%h", c, w,
                                 issue_cache_addr[w*18 +: 18], issue_main_mem_addr[w*18 +: 18], ea, em);
                    end
                end
            end
            // Choose this cycle's inputs.
            issue_ready = ($urandom_range(0, 3) != 0);
            queue_we = 1'b0;
            if (!instr_queue_stall_push && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 9);
                e.t   = (r == 9) ? 2'd3 : 2'(r % 3);
                e.n   = $urandom_range(1, 8);
                e.ar  = 9'($urandom);
                e.ram = 3'(e.ar);
                e.ls  = 7'(e.ar);
                e.ca  = 18'($urandom);
                e.ma  = 18'($urandom);
                e.dca = 18'($urandom);
                e.dma = 18'($urandom);
                set_push(e.t, e.n, e.ar, e.ca, e.dca, e.ma, e.dma);
            end
            // Reference update for the coming edge: retire/advance head, then append.
            if (mq.size() > 0) begin
                if (h.t == 2'd3) begin
                    void'(mq.pop_front());
                    mk = 0;
                end else if (lanes > 0 && issue_ready) begin
                    mk += lanes;
                    if (mk == h.n) begin
                        void'(mq.pop_front());
                        mk = 0;
                    end
                end
            end
            if (queue_we) begin
                if (mq.size() < 16) mq.push_back(e);
                else merr = 1;
            end
            cyc();
        end
        queue_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        queue_we = 1'b0;
        issue_ready = 1'b0;
        set_push(2'd0, 0, 9'd0, 18'd0, 18'd0, 18'd0, 18'd0);
        queue_we = 1'b0;
        test_reset();
        test_single_arith();
        test_ld_st_expand();
        test_ram_wrap();
        test_stall_full();
        test_prog_end();
        test_zero_count();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
